video_timing_ctrl: RTL and testbench

Frame sequencer that generates the vsync/hsync/dvalid stream for an IW x IH image, with programmable blanking. It drives the downstream line/column counting and pixel datapath and supplies matching pixel coordinates. It runs single-shot or in continuous mode under a start/stop handshake, and reports frame completion.

---
 rtl/video_timing_ctrl_if.sv | 28 ++
 rtl/video_timing_ctrl.sv | 177 +++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_ctrl_if.sv
// Control and video-stream bundle for video_timing_ctrl.
// master: the controlling/consuming side; slave: the timing generator.
interface video_timing_ctrl_if #(
  parameter int unsigned IW_DW = 12,
  parameter int unsigned IH_DW = 12
);
  logic             start;
  logic             continuous;
  logic             stop;
  logic             vsync;
  logic             hsync;
  logic             dvalid;
  logic [IW_DW-1:0] x;
  logic [IH_DW-1:0] y;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_cnt;

  modport master (
    output start, continuous, stop,
    input  vsync, hsync, dvalid, x, y, busy, frame_done, frame_cnt
  );

  modport slave (
    input  start, continuous, stop,
    output vsync, hsync, dvalid, x, y, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/video_timing_ctrl.sv
// Frame sequencer: emits vsync/hsync/dvalid plus x/y coordinates for an IW x IH
// image with programmable blanking, single-shot or continuous, with frame counting.
module video_timing_ctrl #(
  parameter int unsigned IW     = 640,
  parameter int unsigned IH     = 480,
  parameter int unsigned IW_DW  = 12,
  parameter int unsigned IH_DW  = 12,
  parameter int unsigned VS_LEN = 2,
  parameter int unsigned VBP    = 4,
  parameter int unsigned HBLANK = 16,
  parameter int unsigned HS_LEN = 4,
  parameter int unsigned VFP    = 8
) (
  input logic                clk,
  input logic                arstn,
  video_timing_ctrl_if.slave bus
);

  localparam int unsigned MaxA   = (IW > HBLANK) ? IW : HBLANK;
  localparam int unsigned MaxB   = (VBP > VFP) ? VBP : VFP;
  localparam int unsigned MaxC   = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxLen = (MaxC > VS_LEN) ? MaxC : VS_LEN;
  localparam int unsigned CW     = $clog2(MaxLen + 1);

  typedef logic [CW-1:0] cnt_t;

  // Phase counter holds cycles remaining in the state minus one; zero marks the last cycle.
  localparam cnt_t VsLast  = cnt_t'(VS_LEN - 1);
  localparam cnt_t VbpLast = cnt_t'(VBP - 1);
  localparam cnt_t ActLast = cnt_t'(IW - 1);
  localparam cnt_t HblLast = cnt_t'(HBLANK - 1);
  localparam cnt_t VfpLast = cnt_t'(VFP - 1);
  localparam cnt_t HsLen   = cnt_t'(HS_LEN);
  localparam cnt_t CntOne  = cnt_t'(1);

  localparam logic [IH_DW-1:0] YLast = IH_DW'(IH - 1);

  typedef enum logic [2:0] {StIdle, StVs, StVbp, StAct, StHbl, StVfp} state_e;

  state_e           state_q;
  cnt_t             cnt_q;
  logic             vsync_q;
  logic             hsync_q;
  logic             dvalid_q;
  logic             busy_q;
  logic             done_q;
  logic             stop_pend_q;
  logic [IW_DW-1:0] x_q;
  logic [IH_DW-1:0] y_q;
  logic [15:0]      fcnt_q;

  logic last;
  logic cont_go;

  assign last    = (cnt_q == '0);
  // A stop arriving in the final cycle still counts as a request for this frame.
  assign cont_go = bus.continuous && !stop_pend_q && !bus.stop;

  // Sequencer: state, phase counter and all registered outputs.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      dvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      fcnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && bus.stop) stop_pend_q <= 1'b1;
      case (state_q)
        StIdle: begin
          // start together with stop yields a single-shot frame
          stop_pend_q <= bus.start && bus.stop;
          if (bus.start) begin
            state_q <= StVs;
            cnt_q   <= VsLast;
            vsync_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StVs: begin
          if (last) begin
            state_q <= StVbp;
            cnt_q   <= VbpLast;
            vsync_q <= 1'b0;
            hsync_q <= (VbpLast < HsLen);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StVbp: begin
          if (last) begin
            state_q  <= StAct;
            cnt_q    <= ActLast;
            hsync_q  <= 1'b0;
            dvalid_q <= 1'b1;
            x_q      <= '0;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            hsync_q <= (cnt_q <= HsLen);
          end
        end
        StAct: begin
          if (last) begin
            dvalid_q <= 1'b0;
            x_q      <= '0;
            if (y_q == YLast) begin
              state_q <= StVfp;
              cnt_q   <= VfpLast;
              if (VfpLast == '0) begin
                done_q <= 1'b1;
                fcnt_q <= fcnt_q + 16'd1;
              end
            end else begin
              state_q <= StHbl;
              cnt_q   <= HblLast;
              hsync_q <= (HblLast < HsLen);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            x_q   <= x_q + 1'b1;
          end
        end
        StHbl: begin
          if (last) begin
            state_q  <= StAct;
            cnt_q    <= ActLast;
            hsync_q  <= 1'b0;
            dvalid_q <= 1'b1;
            y_q      <= y_q + 1'b1;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            hsync_q <= (cnt_q <= HsLen);
          end
        end
        StVfp: begin
          if (last) begin
            y_q <= '0;
            if (cont_go) begin
              state_q <= StVs;
              cnt_q   <= VsLast;
              vsync_q <= 1'b1;
            end else begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // entering the final VFP cycle
            if (cnt_q == CntOne) begin
              done_q <= 1'b1;
              fcnt_q <= fcnt_q + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.vsync      = vsync_q;
  assign bus.hsync      = hsync_q;
  assign bus.dvalid     = dvalid_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: directed scenarios plus random start/stop/continuous
// traffic, each cycle compared against a frame-offset arithmetic model.
module tb_video_timing_ctrl;

  localparam int IW     = 4;
  localparam int IH     = 3;
  localparam int VS_LEN = 2;
  localparam int VBP    = 3;
  localparam int HS_LEN = 1;
  localparam int HBLANK = 2;
  localparam int VFP    = 2;
  localparam int XW     = 4;
  localparam int YW     = 4;

  localparam int P = IW + HBLANK;
  localparam int L = IH * IW + (IH - 1) * HBLANK;
  localparam int F = VS_LEN + VBP + L + VFP;

  logic clk;
  logic arstn;

  video_timing_ctrl_if #(.IW_DW(XW), .IH_DW(YW)) bus ();

  video_timing_ctrl #(
    .IW(IW), .IH(IH), .IW_DW(XW), .IH_DW(YW), .VS_LEN(VS_LEN), .VBP(VBP),
    .HBLANK(HBLANK), .HS_LEN(HS_LEN), .VFP(VFP)
  ) dut (
    .clk  (clk),
    .arstn(arstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: whether a frame is in flight, offset within it, pending stop, count.
  bit          m_act  = 0;
  int          m_t    = 0;
  bit          m_stop = 0;
  logic [15:0] m_cnt  = '0;
  int          done_stamps[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {vsync, hsync, dvalid, x, y} at offset t of a frame.
  function automatic logic [10:0] exp_at(input int t);
    int u, a, p, xx, yy;
    logic vs, hs, dv;
    vs = 0; hs = 0; dv = 0; xx = 0; yy = 0;
    if (t < VS_LEN) begin
      vs = 1;
    end else begin
      u = t - VS_LEN;
      if (u < VBP) begin
        hs = (u >= VBP - HS_LEN);
      end else begin
        a = u - VBP;
        if (a < L) begin
          yy = a / P;
          p  = a % P;
          if (p < IW) begin
            dv = 1;
            xx = p;
          end else begin
            hs = (p >= P - HS_LEN);
          end
        end else begin
          yy = IH - 1;
        end
      end
    end
    return {vs, hs, dv, 4'(xx), 4'(yy)};
  endfunction

  task automatic model_step();
    if (!arstn) begin
      m_act = 0; m_t = 0; m_stop = 0; m_cnt = '0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act  = 1;
        m_t    = 0;
        m_stop = bus.stop;
      end
    end else begin
      if (bus.stop) m_stop = 1;
      if (m_t == F - 1) begin
        if (bus.continuous && !m_stop) begin
          m_t = 0;
        end else begin
          m_act  = 0;
          m_stop = 0;
        end
      end else begin
        m_t++;
        if (m_t == F - 1) m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  task automatic check_cycle();
    logic [10:0] exp_v;
    logic [10:0] obs_v;
    exp_v = m_act ? exp_at(m_t) : 11'd0;
    obs_v = {bus.vsync, bus.hsync, bus.dvalid, bus.x, bus.y};
    chk($sformatf("stream@%0d", cyc), 32'(obs_v), 32'(exp_v));
    chk($sformatf("busy@%0d", cyc), 32'(bus.busy), 32'(m_act));
    chk($sformatf("done@%0d", cyc), 32'(bus.frame_done), 32'(m_act && m_t == F - 1));
    chk($sformatf("fcnt@%0d", cyc), 32'(bus.frame_cnt), 32'(m_cnt));
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_cycle();
    if (bus.frame_done) done_stamps.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int s0;
  int base;

  initial begin
    arstn          = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.stop       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stream", 32'({bus.vsync, bus.hsync, bus.dvalid, bus.x, bus.y}), 32'd0);
    chk("reset_busy_done", 32'({bus.busy, bus.frame_done}), 32'd0);
    chk("reset_fcnt", 32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    ticks(3);

    // Single-shot frame; frame_done lands 22 edges after the start edge.
    done_stamps.delete();
    bus.start = 1'b1;
    tick();
    s0 = cyc;
    bus.start = 1'b0;
    ticks(30);
    chk("single_done_time", 32'(done_stamps.size() > 0 ? done_stamps[0] - s0 : -1), 32'(F - 1));
    chk("single_fcnt", 32'(bus.frame_cnt), 32'd1);
    chk("single_idle", 32'(bus.busy), 32'd0);

    // start re-pulsed while busy does not disturb timing.
    done_stamps.delete();
    bus.start = 1'b1;
    tick();
    s0 = cyc;
    bus.start = 1'b0;
    ticks(10);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(30);
    chk("repulse_done_time", 32'(done_stamps.size() > 0 ? done_stamps[0] - s0 : -1), 32'(F - 1));
    chk("repulse_one_frame", 32'(done_stamps.size()), 32'd1);

    // Continuous: three back-to-back frames, drop continuous during the third.
    done_stamps.delete();
    base = int'(bus.frame_cnt);
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(2 * F + 10);
    bus.continuous = 1'b0;
    ticks(40);
    chk("cont_frames", 32'(done_stamps.size()), 32'd3);
    if (done_stamps.size() == 3) begin
      chk("cont_period1", 32'(done_stamps[1] - done_stamps[0]), 32'(F));
      chk("cont_period2", 32'(done_stamps[2] - done_stamps[1]), 32'(F));
    end
    chk("cont_fcnt", 32'(bus.frame_cnt), 32'(base + 3));

    // Continuous with stop during frame 2 ACT: frame 2 completes, then idle.
    done_stamps.delete();
    base = int'(bus.frame_cnt);
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(F + 8);
    chk("stop_in_act", 32'(bus.dvalid), 32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    ticks(50);
    chk("stop_frames", 32'(done_stamps.size()), 32'd2);
    chk("stop_fcnt", 32'(bus.frame_cnt), 32'(base + 2));
    chk("stop_no_vsync", 32'({bus.vsync, bus.busy}), 32'd0);
    bus.continuous = 1'b0;

    // start held high, single-shot: frames restart one cycle after idle entry.
    bus.start = 1'b1;
    ticks(3 * F);
    bus.start = 1'b0;
    ticks(30);

    // Simultaneous start and stop with continuous high: exactly one frame.
    done_stamps.delete();
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    bus.stop       = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    ticks(2 * F);
    chk("startstop_single", 32'(done_stamps.size()), 32'd1);
    bus.continuous = 1'b0;

    // Asynchronous reset during ACT of line 1.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ticks(12);
    chk("pre_reset_line1", 32'({bus.dvalid, bus.y}), 32'({1'b1, 4'd1}));
    arstn = 1'b0;
    #1;
    chk("arst_stream", 32'({bus.vsync, bus.hsync, bus.dvalid, bus.x, bus.y}), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_fcnt", 32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    ticks(2);
    arstn = 1'b1;
    ticks(5);
    done_stamps.delete();
    bus.start = 1'b1;
    tick();
    s0 = cyc;
    bus.start = 1'b0;
    ticks(30);
    chk("post_reset_done_time", 32'(done_stamps.size() > 0 ? done_stamps[0] - s0 : -1),
        32'(F - 1));
    chk("post_reset_fcnt", 32'(bus.frame_cnt), 32'd1);

    // Random traffic with one asynchronous reset in the middle.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 1500; i++) begin
        bus.start = ($urandom_range(0, 19) == 0);
        bus.stop  = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 49) == 0) bus.continuous = ~bus.continuous;
        tick();
      end
      if (phase == 0) begin
        arstn = 1'b0;
        #1;
        chk("rand_arst", 32'({bus.busy, bus.dvalid, bus.frame_cnt}), 32'd0);
        @(negedge clk);
        tick();
        arstn = 1'b1;
      end
    end
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    ticks(2 * F);
    chk("final_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
